// File: rtl/irq_aggregator.sv
// -----------------------------------------------------------------------------
// irq_aggregator
//
// CSR-mapped interrupt aggregator for the board-control CPLD. Up to eight
// asynchronous, active-high interrupt sources are synchronised, edge/level
// detected according to a per-source trigger mode, and latched into a pending
// register. Enabled pending bits are combined into a single registered IRQ
// line towards the SoC, either as a level or as a one-cycle pulse per new
// event.
//
// Register map (offset from BASE_ADDR, bits >= NUM_INTS read 0 and ignore
// writes):
//   +0 IE     R/W    per-source enable
//   +1 IP     R/W1C  pending; writing 1 clears, writing 0 has no effect
//   +2 TRIG0  R/W    trigger mode bit 0
//   +3 TRIG1  R/W    trigger mode bit 1; mode = {TRIG1[i], TRIG0[i]}
//                    00 level-high, 01 rising, 10 falling, 11 both edges
//   +4 RAW    RO     synchronised input state
//
// Ports:
//   clk      in   1         system clock
//   rst      in   1         synchronous, active-high reset
//   csr_a    in   5         CSR address
//   csr_di   in   8         CSR write data
//   csr_we   in   1         CSR write strobe, one cycle per write
//   csr_do   out  8         CSR read data, 0 outside this block's range
//                           (OR-combined with the other CSR blocks)
//   irqs_in  in   NUM_INTS  raw asynchronous interrupt sources
//   irq      out  1         aggregated interrupt request, registered
// -----------------------------------------------------------------------------
module irq_aggregator #(
    parameter logic [4:0]  BASE_ADDR = 5'h1c,
    parameter int unsigned NUM_INTS  = 8,
    parameter logic [7:0]  DFL_IE    = 8'h00,
    parameter logic [7:0]  DFL_TRIG0 = 8'h00,
    parameter logic [7:0]  DFL_TRIG1 = 8'h00,
    parameter bit          IRQ_PULSE = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          csr_a,
    input  logic [7:0]          csr_di,
    input  logic                csr_we,
    output logic [7:0]          csr_do,
    input  logic [NUM_INTS-1:0] irqs_in,
    output logic                irq
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [2:0] OFF_IE    = 3'd0;
    localparam logic [2:0] OFF_IP    = 3'd1;
    localparam logic [2:0] OFF_TRIG0 = 3'd2;
    localparam logic [2:0] OFF_TRIG1 = 3'd3;
    localparam logic [2:0] OFF_RAW   = 3'd4;

    // One bit per implemented source; NUM_INTS == 8 wraps to 8'hff.
    localparam logic [8:0] MASK_WIDE  = (9'd1 << NUM_INTS) - 9'd1;
    localparam logic [7:0] VALID_MASK = MASK_WIDE[7:0];

    typedef enum logic [1:0] {
        MODE_LEVEL = 2'b00,
        MODE_RISE  = 2'b01,
        MODE_FALL  = 2'b10,
        MODE_BOTH  = 2'b11
    } trig_mode_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [7:0] sync1_q;     // first synchroniser stage (may be metastable)
    logic [7:0] sync2_q;     // synchronised sample s
    logic [7:0] hist_q;      // history h: s delayed by one cycle

    logic [7:0] ie_q,    ie_d;
    logic [7:0] ip_q,    ip_d;
    logic [7:0] trig0_q, trig0_d;
    logic [7:0] trig1_q, trig1_d;
    logic [7:0] prev_q,  prev_d;   // IP & IE of the previous cycle (pulse mode)
    logic       irq_q,   irq_d;

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    logic [7:0] irqs_wide;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] detect;
    logic [7:0] w1c;
    logic [7:0] active;

    logic [5:0] rel_addr;
    logic       addr_hit;
    logic [2:0] reg_off;
    logic       wr_ie;
    logic       wr_ip;
    logic       wr_trig0;
    logic       wr_trig1;

    // Unimplemented source positions are tied low so every internal vector is
    // a uniform 8 bits wide.
    // NOTE: every signal driven from always_comb gets a default first so no
    // path through the block leaves it unassigned and infers a latch.
    always_comb begin
        irqs_wide                = '0;
        irqs_wide[NUM_INTS-1:0]  = irqs_in;
    end

    // -------------------------------------------------------------------------
    // Input synchroniser and history
    // -------------------------------------------------------------------------
    // The synchroniser and history flops keep sampling through reset. That way
    // the history already equals the synchronised value when reset is released,
    // and an input held high across reset does not look like a fresh edge.
    // NOTE: these flops have no reset on purpose; their contents are only ever
    // a delayed copy of the inputs and are flushed within three cycles.
    // NOTE: sequential state is always written with non-blocking assignments
    // so every flop samples the pre-edge value of its source.
    always_ff @(posedge clk) begin
        sync1_q <= irqs_wide;
        sync2_q <= sync1_q;
        hist_q  <= sync2_q;
    end

    // -------------------------------------------------------------------------
    // Event detection
    // -------------------------------------------------------------------------
    assign rise = sync2_q & ~hist_q;
    assign fall = ~sync2_q & hist_q;

    always_comb begin
        detect = '0;
        for (int i = 0; i < 8; i++) begin
            case (trig_mode_e'({trig1_q[i], trig0_q[i]}))
                MODE_LEVEL: detect[i] = sync2_q[i];
                MODE_RISE:  detect[i] = rise[i];
                MODE_FALL:  detect[i] = fall[i];
                MODE_BOTH:  detect[i] = rise[i] | fall[i];
                default:    detect[i] = 1'b0;
            endcase
        end
        detect = detect & VALID_MASK;
    end

    // -------------------------------------------------------------------------
    // CSR address decode
    // -------------------------------------------------------------------------
    // The window does not wrap past the top of the 5-bit address space: with a
    // base near the top, registers beyond address 5'h1f are simply not
    // reachable rather than aliasing onto another block at the bottom of the
    // map, which would corrupt the OR-combined read bus.
    assign rel_addr = {1'b0, csr_a} - {1'b0, BASE_ADDR};
    assign addr_hit = (csr_a >= BASE_ADDR) && (rel_addr < 6'd5);
    assign reg_off  = rel_addr[2:0];

    assign wr_ie    = csr_we && addr_hit && (reg_off == OFF_IE);
    assign wr_ip    = csr_we && addr_hit && (reg_off == OFF_IP);
    assign wr_trig0 = csr_we && addr_hit && (reg_off == OFF_TRIG0);
    assign wr_trig1 = csr_we && addr_hit && (reg_off == OFF_TRIG1);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        ie_d    = ie_q;
        trig0_d = trig0_q;
        trig1_d = trig1_q;

        if (wr_ie) begin
            ie_d = csr_di & VALID_MASK;
        end
        if (wr_trig0) begin
            trig0_d = csr_di & VALID_MASK;
        end
        if (wr_trig1) begin
            trig1_d = csr_di & VALID_MASK;
        end

        // Clear is applied before set, so an event in the same cycle as a
        // W1C of the same bit keeps the bit pending. In level mode this also
        // re-sets the bit every cycle while the source stays high.
        w1c  = wr_ip ? (csr_di & VALID_MASK) : 8'h00;
        ip_d = (ip_q & ~w1c) | detect;

        active = ip_q & ie_q;
        prev_d = active;
        if (IRQ_PULSE) begin
            // One pulse per enabled pending bit going 0->1, including a bit
            // that becomes enabled while already pending.
            irq_d = |(active & ~prev_q);
        end else begin
            irq_d = |active;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ie_q    <= DFL_IE    & VALID_MASK;
            ip_q    <= 8'h00;
            trig0_q <= DFL_TRIG0 & VALID_MASK;
            trig1_q <= DFL_TRIG1 & VALID_MASK;
            prev_q  <= 8'h00;
            irq_q   <= 1'b0;
        end else begin
            ie_q    <= ie_d;
            ip_q    <= ip_d;
            trig0_q <= trig0_d;
            trig1_q <= trig1_d;
            prev_q  <= prev_d;
            irq_q   <= irq_d;
        end
    end

    assign irq = irq_q;

    // -------------------------------------------------------------------------
    // CSR read mux (combinational, no read side effects)
    // -------------------------------------------------------------------------
    always_comb begin
        csr_do = 8'h00;
        if (addr_hit) begin
            case (reg_off)
                OFF_IE:    csr_do = ie_q;
                OFF_IP:    csr_do = ip_q;
                OFF_TRIG0: csr_do = trig0_q;
                OFF_TRIG1: csr_do = trig1_q;
                OFF_RAW:   csr_do = sync2_q & VALID_MASK;
                default:   csr_do = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_aggregator.sv
// -----------------------------------------------------------------------------
// tb_irq_aggregator
//
// Two aggregators share one CSR bus, as they would on the board:
//   dut_a : BASE 5'h1c, 8 sources, level irq, all-zero reset values
//   dut_b : BASE 5'h08, 3 sources, pulse irq, TRIG0 resets to rising mode
// The stimulus process drives one "slot" per clock (inputs change 1 ns after
// the rising edge) and pushes the expected observations for that slot into a
// queue; the monitor samples on the falling edge and pops/compares them.
// -----------------------------------------------------------------------------
module tb_irq_aggregator;

    localparam logic [4:0] A_IE   = 5'h1c;
    localparam logic [4:0] A_IP   = 5'h1d;
    localparam logic [4:0] A_T0   = 5'h1e;
    localparam logic [4:0] A_T1   = 5'h1f;
    localparam logic [4:0] B_IE   = 5'h08;
    localparam logic [4:0] B_IP   = 5'h09;
    localparam logic [4:0] B_T0   = 5'h0a;
    localparam logic [4:0] B_T1   = 5'h0b;
    localparam logic [4:0] B_RAW  = 5'h0c;
    localparam logic [4:0] B_OUT  = 5'h0d;

    localparam int K_RD   = 0;
    localparam int K_IRQA = 1;
    localparam int K_IRQB = 2;

    logic       clk;
    logic       rst_a;
    logic       rst_b;
    logic [4:0] csr_a;
    logic [7:0] csr_di;
    logic       csr_we;
    logic [7:0] do_a;
    logic [7:0] do_b;
    logic [7:0] csr_bus;
    logic [7:0] irqs_a;
    logic [2:0] irqs_b;
    logic       irq_a;
    logic       irq_b;

    assign csr_bus = do_a | do_b;

    irq_aggregator #(
        .BASE_ADDR (5'h1c),
        .NUM_INTS  (8),
        .DFL_IE    (8'h00),
        .DFL_TRIG0 (8'h00),
        .DFL_TRIG1 (8'h00),
        .IRQ_PULSE (1'b0)
    ) dut_a (
        .clk     (clk),
        .rst     (rst_a),
        .csr_a   (csr_a),
        .csr_di  (csr_di),
        .csr_we  (csr_we),
        .csr_do  (do_a),
        .irqs_in (irqs_a),
        .irq     (irq_a)
    );

    irq_aggregator #(
        .BASE_ADDR (5'h08),
        .NUM_INTS  (3),
        .DFL_IE    (8'h00),
        .DFL_TRIG0 (8'hff),
        .DFL_TRIG1 (8'h00),
        .IRQ_PULSE (1'b1)
    ) dut_b (
        .clk     (clk),
        .rst     (rst_b),
        .csr_a   (csr_a),
        .csr_di  (csr_di),
        .csr_we  (csr_we),
        .csr_do  (do_b),
        .irqs_in (irqs_b),
        .irq     (irq_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard
    string      name_q[$];
    int         kind_q[$];
    logic [7:0] val_q[$];
    int         obs_n;
    int         checks;
    int         errors;

    task automatic push_exp(input int kind, input logic [7:0] val, input string name);
        name_q.push_back(name);
        kind_q.push_back(kind);
        val_q.push_back(val);
        obs_n++;
    endtask

    task automatic expect_rd(input logic [4:0] addr, input logic [7:0] val, input string name);
        csr_a = addr;
        push_exp(K_RD, val, name);
    endtask

    task automatic expect_irq(input int kind, input logic val, input string name);
        push_exp(kind, {7'd0, val}, name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        obs_n  = 0;
        csr_we = 1'b0;
    endtask

    task automatic wr(input logic [4:0] addr, input logic [7:0] data);
        csr_a  = addr;
        csr_di = data;
        csr_we = 1'b1;
        tick();
    endtask

    // Monitor: consumes the expectations queued for the current slot.
    initial begin
        string      nm;
        int         kd;
        logic [7:0] ev;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            for (int i = 0; i < obs_n; i++) begin
                checks++;
                if (name_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_underflow: observation requested with empty queue");
                end else begin
                    nm  = name_q.pop_front();
                    kd  = kind_q.pop_front();
                    ev  = val_q.pop_front();
                    act = (kd == K_RD)   ? csr_bus :
                          (kd == K_IRQA) ? {7'd0, irq_a} : {7'd0, irq_b};
                    if (act !== ev) begin
                        errors++;
                        $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, ev, $time);
                    end
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // Stimulus
    initial begin
        checks = 0;
        errors = 0;
        obs_n  = 0;
        rst_a  = 1'b1;
        rst_b  = 1'b1;
        csr_a  = 5'h00;
        csr_di = 8'h00;
        csr_we = 1'b0;
        irqs_a = 8'h00;
        irqs_b = 3'b000;
        repeat (4) tick();
        rst_a = 1'b0;
        rst_b = 1'b0;
        tick();

        // ---- Reset state ----
        expect_rd(A_IE, 8'h00, "rst_a_ie");
        expect_irq(K_IRQA, 1'b0, "rst_irq_a");
        expect_irq(K_IRQB, 1'b0, "rst_irq_b");
        tick();
        expect_rd(A_IP, 8'h00, "rst_a_ip");
        tick();
        expect_rd(B_T0, 8'h07, "rst_b_trig0_masked");
        tick();
        expect_rd(B_T1, 8'h00, "rst_b_trig1");
        tick();
        expect_rd(B_IE, 8'h00, "rst_b_ie");
        tick();

        // ---- 1: rising mode on A src0 ----
        wr(A_T0, 8'h01);
        wr(A_IE, 8'h01);
        irqs_a[0] = 1'b1;                              // slot k
        tick();
        tick();
        irqs_a[0] = 1'b0;                              // slot k+2
        expect_rd(A_IP, 8'h00, "t1_ip_before");
        tick();
        expect_rd(A_IP, 8'h01, "t1_ip_set");           // k+3
        expect_irq(K_IRQA, 1'b0, "t1_irq_before");
        tick();
        expect_rd(A_IP, 8'h01, "t1_ip_held");          // k+4
        expect_irq(K_IRQA, 1'b1, "t1_irq_set");
        tick();
        wr(A_IP, 8'h01);                               // W1C in k+5
        expect_rd(A_IP, 8'h00, "t1_ip_clr");           // k+6
        tick();
        expect_rd(A_IP, 8'h00, "t1_ip_stays_clr");     // k+7
        expect_irq(K_IRQA, 1'b0, "t1_irq_clr");
        tick();

        // ---- 2: level mode on A src2 ----
        irqs_a[2] = 1'b1;                              // slot m
        tick();
        tick();
        tick();
        expect_rd(A_IP, 8'h04, "t2_ip_level");         // m+3
        tick();
        wr(A_IP, 8'h04);                               // W1C in m+4
        expect_rd(A_IP, 8'h04, "t2_ip_reset_by_level"); // m+5
        expect_irq(K_IRQA, 1'b0, "t2_irq_masked");
        tick();
        irqs_a[2] = 1'b0;                              // m+6
        tick();
        tick();
        wr(A_IP, 8'h04);                               // W1C in m+8
        expect_rd(A_IP, 8'h00, "t2_ip_clr");           // m+9
        tick();
        tick();
        expect_rd(A_IP, 8'h00, "t2_ip_stays_clr");
        tick();

        // ---- 3: falling mode on A src1, masked ----
        wr(A_IE, 8'h00);
        wr(A_T1, 8'h02);
        irqs_a[1] = 1'b1;
        repeat (4) tick();
        expect_rd(A_IP, 8'h00, "t3_rise_ignored");
        tick();
        irqs_a[1] = 1'b0;                              // slot n
        tick();
        tick();
        tick();
        expect_rd(A_IP, 8'h02, "t3_ip_fall");          // n+3
        tick();
        expect_irq(K_IRQA, 1'b0, "t3_irq_masked");     // n+4
        tick();
        wr(A_IE, 8'h02);                               // n+5
        expect_rd(A_IE, 8'h02, "t3_ie_written");       // n+6
        tick();
        expect_irq(K_IRQA, 1'b1, "t3_irq_enabled");    // n+7
        tick();

        // ---- 4: both edges on B src0, pulse irq ----
        wr(B_T1, 8'h01);
        wr(B_IE, 8'h01);
        for (int c = 0; c < 15; c++) begin
            irqs_b[0] = (c < 8);
            expect_irq(K_IRQB, (c == 4) || (c == 12), $sformatf("t4_pulse_c%0d", c));
            if (c == 6) begin
                csr_a  = B_IP;
                csr_di = 8'h01;
                csr_we = 1'b1;
            end else if (c == 3 || c == 11) begin
                expect_rd(B_IP, 8'h01, $sformatf("t4_ip_set_c%0d", c));
            end else if (c == 7) begin
                expect_rd(B_IP, 8'h00, "t4_ip_clr");
            end
            tick();
        end
        wr(B_IP, 8'h01);
        irqs_b[0] = 1'b1;                              // slot q
        tick();
        tick();
        csr_a  = B_IP;                                 // W1C in q+2, edge detected in q+2
        csr_di = 8'h01;
        csr_we = 1'b1;
        tick();
        expect_rd(B_IP, 8'h01, "t4_set_beats_w1c");    // q+3
        tick();
        expect_irq(K_IRQB, 1'b1, "t4_pulse_after_race"); // q+4
        tick();
        expect_irq(K_IRQB, 1'b0, "t4_pulse_ends");
        tick();

        // ---- 5: NUM_INTS=3 masking, out-of-range read, reset ----
        wr(B_IE, 8'hff);
        expect_rd(B_IE, 8'h07, "t5_ie_masked");
        tick();
        expect_rd(B_OUT, 8'h00, "t5_out_of_range");
        tick();
        irqs_b = 3'b111;
        tick();
        tick();
        tick();
        expect_rd(B_IP, 8'h07, "t5_ip_all");
        tick();
        rst_b = 1'b1;
        tick();
        expect_rd(B_IP, 8'h00, "t5_rst_ip");
        expect_irq(K_IRQB, 1'b0, "t5_rst_irq");
        tick();
        expect_rd(B_IE, 8'h00, "t5_rst_ie");
        rst_b = 1'b0;
        tick();
        repeat (4) tick();
        expect_rd(B_IP, 8'h00, "t5_no_ip_after_rst");
        tick();
        expect_rd(B_RAW, 8'h07, "t5_raw");
        expect_irq(K_IRQB, 1'b0, "t5_irq_quiet");
        tick();
        expect_irq(K_IRQA, 1'b1, "t5_irq_a_unaffected");
        tick();
        tick();

        checks++;
        if (name_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", name_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
